// File: rtl/load_response_unit.sv
// Memory-stage load responder: issues a word-aligned read, extracts and extends
// the addressed byte/half/word, and reports misalignment or timeout as wb_err.
//
// state | meaning
// IDLE  | ready for a load request
// REQ   | read request presented to memory, waiting for acceptance
// WAIT  | read accepted, waiting for response (timeout counter running)
// DRAIN | flushed after issue; swallow the response, no writeback
// DONE  | one-cycle writeback strobe
module load_response_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  input  logic        flush,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic        stall
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;

  localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic [29:0] waddr_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        wb_err_q;
  logic        accept;
  logic        legal;
  logic        timeout;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  assign accept  = (state == S_IDLE) && req_valid && !flush;
  assign timeout = (cnt == TC_LAST);

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = !req_addr[0];
      3'b010:         legal = (req_addr[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
  end

  always_comb begin
    byte_sel = mem_resp_data[8*off_q +: 8];
    half_sel = off_q[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];
    ext_data = mem_resp_data;
    case (f3_q)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext_data = {24'b0, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext_data = {16'b0, half_sel};
      default: ext_data = mem_resp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = legal ? S_REQ : S_DONE;
      // A flush that coincides with acceptance still leaves a read in flight.
      S_REQ: begin
        if (flush)              state_nx = mem_req_ready ? S_DRAIN : S_IDLE;
        else if (mem_req_ready) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (flush)                          state_nx = mem_resp_valid ? S_IDLE : S_DRAIN;
        else if (mem_resp_valid || timeout) state_nx = S_DONE;
      end
      S_DRAIN: if (mem_resp_valid || timeout) state_nx = S_IDLE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state == S_IDLE);
    mem_req_valid = (state == S_REQ);
    wb_valid      = (state == S_DONE);
    stall         = (state != S_IDLE) || accept;
  end

  assign mem_req_addr = {waddr_q, 2'b00};
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_err       = wb_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      waddr_q   <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        rd_q    <= req_rd;
        waddr_q <= req_addr[31:2];
        if (!legal) begin
          wb_rd_q   <= req_rd;
          wb_data_q <= '0;
          wb_err_q  <= 1'b1;
        end
      end
      case (state)
        S_REQ: cnt <= '0;
        S_WAIT: begin
          cnt <= flush ? 8'd0 : cnt + 8'd1;
          if (!flush && (mem_resp_valid || timeout)) begin
            wb_rd_q   <= rd_q;
            wb_err_q  <= !mem_resp_valid;
            wb_data_q <= mem_resp_valid ? ext_data : 32'd0;
          end
        end
        S_DRAIN: cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_response_unit.sv
// Directed bench for load_response_unit: stimulus pushes expected writebacks,
// a negedge monitor pops and compares them whenever wb_valid is seen.
module tb_load_response_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;
  logic        stall;

  load_response_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_rd(req_rd), .req_ready(req_ready), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_err(wb_err), .stall(stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb got wb_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_data", wb_data, e.data);
        chk("wb_err", 32'(wb_err), 32'(e.err));
        chk("wb_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wb_timeout got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_mem_req_addr"}, mem_req_addr, 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_wb_err"}, 32'(wb_err), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  task automatic present(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_addr   = addr;
    req_rd     = rd;
  endtask

  task automatic legal_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                            input logic [31:0] word, input logic [31:0] exp_data);
    exp_t e;
    present(f3, addr, rd);
    e.rd = rd; e.data = exp_data; e.err = 1'b0; e.at = cyc + 3;
    exp_q.push_back(e);
    #1 chk("stall_accept", 32'(stall), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
    chk("mem_req_addr", mem_req_addr, {addr[31:2], 2'b00});
    chk("stall_req", 32'(stall), 32'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("stall_wait", 32'(stall), 32'd1);
    mem_resp_valid = 1'b1;
    mem_resp_data  = word;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    tick();
    wait_empty();
  endtask

  task automatic err_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    exp_t e;
    present(f3, addr, rd);
    e.rd = rd; e.data = 32'd0; e.err = 1'b1; e.at = cyc + 1;
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
    chk("err_no_mem_req", 32'(mem_req_valid), 32'd0);
    tick();
    chk("err_idle_no_req", 32'(mem_req_valid), 32'd0);
    wait_empty();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_rd = '0;
    flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick(); tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    legal_load(3'b010, 32'h100, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF);
    legal_load(3'b000, 32'h103, 5'd6,  32'h80FF7F01, 32'hFFFFFF80);
    legal_load(3'b100, 32'h103, 5'd7,  32'h80FF7F01, 32'h00000080);
    legal_load(3'b000, 32'h101, 5'd8,  32'h80FF7F01, 32'h0000007F);
    legal_load(3'b100, 32'h102, 5'd9,  32'h80FF7F01, 32'h000000FF);
    legal_load(3'b001, 32'h102, 5'd10, 32'h80011234, 32'hFFFF8001);
    legal_load(3'b101, 32'h100, 5'd11, 32'h80011234, 32'h00001234);
    legal_load(3'b001, 32'h200, 5'd12, 32'h0000F00D, 32'hFFFFF00D);
    legal_load(3'b101, 32'h202, 5'd13, 32'hF00D0000, 32'h0000F00D);

    err_load(3'b010, 32'h101, 5'd14);
    err_load(3'b011, 32'h100, 5'd15);
    err_load(3'b001, 32'h101, 5'd16);
    err_load(3'b110, 32'h100, 5'd17);
    err_load(3'b111, 32'h100, 5'd18);

    // Memory stalls acceptance, then a flush cancels the request.
    present(3'b010, 32'h204, 5'd1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(mem_req_valid), 32'd1);
      chk("hold_addr", mem_req_addr, 32'h204);
      mem_resp_valid = (i == 2);
      tick();
    end
    mem_resp_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_req_valid", 32'(mem_req_valid), 32'd0);
    chk("flush_req_ready", 32'(req_ready), 32'd1);
    chk("flush_stall", 32'(stall), 32'd0);
    tick(); tick();

    // Flush in WAIT: late response is discarded.
    present(3'b010, 32'h300, 5'd2);
    tick();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_req_ready", 32'(req_ready), 32'd0);
    chk("drain_stall", 32'(stall), 32'd1);
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h12345678;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    chk("drain_exit", 32'(req_ready), 32'd1);
    tick(); tick();

    // Flush and acceptance in the same REQ cycle: read is in flight, so drain.
    present(3'b010, 32'h304, 5'd3);
    tick();
    req_valid = 1'b0;
    mem_req_ready = 1'b1; flush = 1'b1;
    tick();
    mem_req_ready = 1'b0; flush = 1'b0;
    chk("flush_ack_drain", 32'(req_ready), 32'd0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    chk("flush_ack_exit", 32'(req_ready), 32'd1);
    tick();

    // Flush and response in the same WAIT cycle: straight back to IDLE.
    present(3'b010, 32'h308, 5'd4);
    tick();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    flush = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFEF00D;
    tick();
    flush = 1'b0; mem_resp_valid = 1'b0;
    chk("flush_resp_idle", 32'(req_ready), 32'd1);
    tick();

    // Flush during DONE does not cancel the committed writeback.
    present(3'b100, 32'h402, 5'd19);
    e.rd = 5'd19; e.data = 32'h000000AB; e.err = 1'b0; e.at = cyc + 3;
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h00AB0000;
    tick();
    mem_resp_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("done_flush_idle", 32'(req_ready), 32'd1);
    wait_empty();

    // Timeout in WAIT: error writeback TO cycles after entering WAIT.
    present(3'b010, 32'h500, 5'd7);
    e.rd = 5'd7; e.data = 32'd0; e.err = 1'b1; e.at = cyc + 2 + TO;
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < TO + 1; i++) tick();
    wait_empty();

    // Timeout in DRAIN exits silently after TO cycles.
    present(3'b010, 32'h504, 5'd8);
    tick();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < TO - 1; i++) tick();
    chk("drain_to_last", 32'(req_ready), 32'd0);
    tick();
    chk("drain_to_exit", 32'(req_ready), 32'd1);
    tick();

    // Reset mid-WAIT clears everything; the late response is ignored.
    present(3'b010, 32'h600, 5'd9);
    tick();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_reset_vals("midrst");
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h55AA55AA;
    tick();
    mem_resp_valid = 1'b0;
    chk("post_rst_idle", 32'(req_ready), 32'd1);
    tick(); tick();
    wait_empty();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
